data_memory_unit: RTL and testbench

//   Block-organised main data memory behind the CPU data cache.

---
 rtl/data_memory_unit_pkg.sv | 13 +
 rtl/data_memory_unit.sv | 101 ++++++++++
 tb/tb_data_memory_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/data_memory_unit_pkg.sv
// Shared widths and controller state encoding for the block-organised data memory.
package data_memory_unit_pkg;

  localparam int BLOCK_W = 128;
  localparam int ADDR_W  = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/data_memory_unit.sv
// Main data memory serving whole 128-bit blocks to the d-cache over a
// multi-cycle READ/WRITE handshake, stalling the requester with BUSYWAIT.
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [BLOCK_W-1:0] WRITEDATA,
  output logic [BLOCK_W-1:0] READDATA,
  output logic               BUSYWAIT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               do_op;

  logic [IDX_W-1:0]   addr_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic               wr_q;
  logic [BLOCK_W-1:0] readdata_q;
  logic [BLOCK_W-1:0] mem_q [0:DEPTH-1];

  // Upper address bits alias onto the same blocks (wrap-around).
  logic unused_addr;
  assign unused_addr = ^ADDRESS[ADDR_W-1:IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    do_op   = 1'b0;
    case (state_q)
      IDLE: begin
        if (READ || WRITE) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          do_op   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is captured once at acceptance; later input changes are ignored.
  // READ and WRITE together resolve to a write.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= ADDRESS[IDX_W-1:0];
      wdata_q <= WRITEDATA;
      wr_q    <= WRITE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      readdata_q <= '0;
    end else if (do_op) begin
      if (wr_q) begin
        mem_q[addr_q] <= wdata_q;
      end else begin
        readdata_q <= mem_q[addr_q];
      end
    end
  end

  assign READDATA = readdata_q;
  assign BUSYWAIT = (READ || WRITE) && (state_q != ACK);

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: a driver issues handshaked block
// requests against an array model; a monitor checks every acknowledge.
module tb_data_memory_unit;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         READ;
  logic         WRITE;
  logic [27:0]  ADDRESS;
  logic [127:0] WRITEDATA;
  logic [127:0] READDATA;
  logic         BUSYWAIT;

  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
    .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int unsigned  issue;
    logic [127:0] rd;
  } exp_t;
  exp_t sb[$];

  // Reference: plain array of blocks plus the last value a read returned.
  logic [127:0] model_mem [DEPTH];
  logic [127:0] model_rd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rd = '0;
  endtask

  // Monitor: the acknowledge cycle is the one where a request is held but BUSYWAIT is low.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET && (READ || WRITE) && !BUSYWAIT) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 128'(cyc), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("ack_latency", 128'(cyc), 128'(e.issue + 1 + LATENCY));
        chk("readdata", READDATA, e.rd);
      end
    end
  end

  // perturb: 0 none, 1 WRITEDATA to all-ones in cycle 2, 2 random ADDRESS/WRITEDATA churn
  task automatic do_req(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, input int perturb);
    exp_t e;
    int   n;
    int unsigned idx;
    idx = a % DEPTH;
    if (wr) model_mem[idx] = d;
    else    model_rd = model_mem[idx];
    e.issue = cyc;
    e.rd    = model_rd;
    sb.push_back(e);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    #1;
    chk("busywait_rise", 128'(BUSYWAIT), 128'(1));
    n = 0;
    forever begin
      @(negedge CLK);
      n++;
      if (!BUSYWAIT) break;
      if (n > LATENCY + 3) begin
        chk("ack_timeout", 128'(n), 128'(LATENCY + 1));
        sb.delete();
        break;
      end
      if (perturb == 1 && n == 2) WRITEDATA = '1;
      if (perturb == 2 && n >= 2) begin
        ADDRESS   = 28'($urandom());
        WRITEDATA = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic abort_write(input logic [27:0] a, input logic [127:0] d);
    READ = 1'b0; WRITE = 1'b1; ADDRESS = a; WRITEDATA = d;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1; WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [27:0]  a;
    logic [127:0] d;
    int           op;
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    model_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("busywait_in_reset", 128'(BUSYWAIT), 128'(1));
    READ = 1'b0;
    #1;
    chk("busywait_idle", 128'(BUSYWAIT), 128'(0));
    chk("readdata_reset", READDATA, '0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    do_req(1, 0, 28'h0000003, '0, 0);
    do_req(0, 1, 28'h0000005, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0);
    do_req(1, 0, 28'h0000005, '0, 0);
    do_req(0, 1, 28'h0000105, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0);
    do_req(1, 0, 28'h0000005, '0, 0);
    do_req(0, 1, 28'h0000020, {16{8'hA5}}, 1);
    do_req(1, 0, 28'h0000020, '0, 0);

    do_req(0, 1, 28'h0000007, 128'h1234, 0);
    abort_write(28'h0000007, {16{8'h5A}});
    chk("busywait_after_abort", 128'(BUSYWAIT), 128'(0));
    chk("readdata_after_abort", READDATA, '0);
    do_req(1, 0, 28'h0000007, '0, 0);
    do_req(1, 0, 28'h0000005, '0, 0);

    do_req(1, 1, 28'h0000009, '1, 0);
    do_req(1, 0, 28'h0000009, '0, 0);

    for (int i = 0; i < 60; i++) begin
      a      = 28'($urandom());
      a[7:0] = 8'($urandom_range(0, 15));
      d      = {$urandom(), $urandom(), $urandom(), $urandom()};
      op     = int'($urandom_range(0, 4));
      if (op <= 1)      do_req(1, 0, a, d, int'($urandom_range(0, 1)) * 2);
      else if (op <= 3) do_req(0, 1, a, d, int'($urandom_range(0, 1)) * 2);
      else              do_req(1, 1, a, d, 0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLK);
    if (sb.size() != 0) chk("scoreboard_drain", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
